cb_master_queue: RTL and testbench

CB_MASTER_QUEUE -- requirements
Module: cb_master_queue

---
 rtl/cb_master_queue.sv | 142 ++++++++++++++
 tb/tb_cb_master_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_master_queue.sv
// Crossbar master-side request queue: buffers client requests and issues them in order to a crossbar master port.
// Optional ack watchdog enabled by defining CB_MASTER_QUEUE_TIMEOUT_EN.

package cross_bar_pkg;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        addr_t addr;
        logic  cmd;
        data_t wdata;
    } cb_req_t;
endpackage

module cb_master_queue
    import cross_bar_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  addr_t                        in_addr,
    input  logic                         in_cmd,
    input  data_t                        in_wdata,
    output logic                         rsp_valid,
    output data_t                        rsp_rdata,
    output logic                         rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         master_req,
    output addr_t                        master_addr,
    output logic                         master_cmd,
    output data_t                        master_wdata,
    input  logic                         master_ack,
    input  data_t                        master_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    // Out-of-range parameters leave this marker block in the elaborated hierarchy.
    if (DEPTH < 2 || DEPTH > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_out_of_range
    end

    cb_req_t          mem [DEPTH];
    cb_req_t          head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_c;
    logic             ack_pop_c;
    logic             pop_c;
    logic             timeout_c;
    logic             head_is_read;

    assign in_ready     = (level < LVL_W'(DEPTH));
    assign master_req   = (level != '0);
    assign head         = mem[rd_ptr];
    assign master_addr  = head.addr;
    assign master_cmd   = head.cmd;
    assign master_wdata = head.wdata;
    assign head_is_read = !head.cmd;

    assign push_c    = in_valid && in_ready;
    assign ack_pop_c = master_req && master_ack;
    assign pop_c     = ack_pop_c || timeout_c;

`ifdef CB_MASTER_QUEUE_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Fires on the last unacked cycle of the allowed window; a same-cycle ack wins.
    assign timeout_c = master_req && !master_ack && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt <= '0;
        end else if (pop_c || !master_req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= timeout_c;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Payload storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{addr: in_addr, cmd: in_cmd, wdata: in_wdata};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Reads and timeouts produce a one-cycle response; rdata holds between responses.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= pop_c && (head_is_read || timeout_c);
            if (timeout_c) begin
                rsp_rdata <= '0;
            end else if (ack_pop_c && head_is_read) begin
                rsp_rdata <= master_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cb_master_queue.sv
// Self-checking bench for cb_master_queue: queue-based reference model, directed scenarios and random traffic.
// Timeout scenarios run when CB_MASTER_QUEUE_TIMEOUT_EN is defined.

module tb_cb_master_queue;
    import cross_bar_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             aresetn;
    logic             in_valid;
    logic             in_ready;
    addr_t            in_addr;
    logic             in_cmd;
    data_t            in_wdata;
    logic             rsp_valid;
    data_t            rsp_rdata;
    logic             rsp_err;
    logic [LVL_W-1:0] level;
    logic             master_req;
    addr_t            master_addr;
    logic             master_cmd;
    data_t            master_wdata;
    logic             master_ack;
    data_t            master_rdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cb_master_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .aresetn(aresetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_cmd(in_cmd), .in_wdata(in_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .level(level),
        .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
        .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata)
    );

    // Reference model: FIFO of pending requests plus the last response.
    cb_req_t mq[$];
    logic    m_rv;
    logic    m_re;
    data_t   m_rd;
    int      m_age;

    always @(posedge clk or negedge aresetn) begin : model
        bit      has;
        bit      full;
        bit      tmo;
        cb_req_t hd;
        if (!aresetn) begin
            mq.delete();
            m_rv  = 1'b0;
            m_re  = 1'b0;
            m_rd  = '0;
            m_age = 0;
        end else begin
            has  = (mq.size() != 0);
            full = (mq.size() >= DEPTH);
            tmo  = 1'b0;
`ifdef CB_MASTER_QUEUE_TIMEOUT_EN
            tmo = has && !master_ack && (m_age + 1 == TMO);
`endif
            m_rv = 1'b0;
            m_re = 1'b0;
            if ((has && master_ack) || tmo) begin
                hd    = mq.pop_front();
                m_age = 0;
                if (tmo) begin
                    m_rv = 1'b1;
                    m_re = 1'b1;
                    m_rd = '0;
                end else if (!hd.cmd) begin
                    m_rv = 1'b1;
                    m_rd = master_rdata;
                end
            end else begin
                m_age = has ? m_age + 1 : 0;
            end
            if (in_valid && !full) begin
                mq.push_back('{addr: in_addr, cmd: in_cmd, wdata: in_wdata});
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (aresetn === 1'b1) begin
            chk("level", 64'(level), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("master_req", 64'(master_req), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("master_addr", 64'(master_addr), 64'(mq[0].addr));
                chk("master_cmd", 64'(master_cmd), 64'(mq[0].cmd));
                chk("master_wdata", 64'(master_wdata), 64'(mq[0].wdata));
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            chk("rsp_err", 64'(rsp_err), 64'(m_re));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
        end
    end

    task automatic step(input bit iv, input addr_t a, input bit c, input data_t d,
                        input bit ack, input data_t rd);
        in_valid     = iv;
        in_addr      = a;
        in_cmd       = c;
        in_wdata     = d;
        master_ack   = ack;
        master_rdata = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit ack);
        step(1'b0, '0, 1'b0, '0, ack, 32'hDEAD_BEEF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        aresetn      = 1'b0;
        in_valid     = 1'b0;
        in_addr      = '0;
        in_cmd       = 1'b0;
        in_wdata     = '0;
        master_ack   = 1'b0;
        master_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_master_req", 64'(master_req), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_rsp_err", 64'(rsp_err), 64'd0);

        // Single read: request visible one cycle after push, ack three cycles later.
        step(1'b1, 16'h0010, 1'b0, '0, 1'b0, '0);
        chk("rd_req", 64'(master_req), 64'd1);
        chk("rd_addr", 64'(master_addr), 64'h10);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_A5A5);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hA5A5);
        chk("rd_level", 64'(level), 64'd0);
        idle(1'b0);
        chk("rd_rsp_pulse", 64'(rsp_valid), 64'd0);
        chk("rd_rdata_hold", 64'(rsp_rdata), 64'hA5A5);

        // Fill with writes, refuse a fifth, then drain back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 16'(16'h0100 + i), 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, '0);
        end
        chk("full_level", 64'(level), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 16'h01FF, 1'b1, 32'hFFFF_FFFF, 1'b0, '0);
        chk("full_reject", 64'(level), 64'd4);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_addr", 64'(master_addr), 64'(16'h0100 + i));
            chk("drain_req", 64'(master_req), 64'd1);
            step(1'b0, '0, 1'b0, '0, 1'b1, 32'h1111_0000 + 32'(i));
            chk("drain_no_rsp", 64'(rsp_valid), 64'd0);
        end
        chk("drain_level", 64'(level), 64'd0);

        // Simultaneous push and pop at level 2.
        step(1'b1, 16'h0200, 1'b0, '0, 1'b0, '0);
        step(1'b1, 16'h0201, 1'b0, '0, 1'b0, '0);
        step(1'b1, 16'h0202, 1'b1, 32'h0000_0202, 1'b1, 32'h0000_0055);
        chk("pp_level", 64'(level), 64'd2);
        chk("pp_head", 64'(master_addr), 64'h0201);
        chk("pp_rsp", 64'(rsp_rdata), 64'h55);
        repeat (DEPTH + 1) idle(1'b1);

        // Random mixed traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 55, 16'($urandom), 1'($urandom), 32'($urandom),
                 $urandom_range(0, 99) < 45, 32'($urandom));
        end

        // Reset mid-transfer with three requests queued.
        repeat (DEPTH + 1) idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'(16'h0400 + i), 1'b0, '0, 1'b0, '0);
        end
        chk("pre_rst_level", 64'(level), 64'd3);
        master_ack = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        chk("async_level", 64'(level), 64'd0);
        chk("async_req", 64'(master_req), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            chk("post_rst_no_req", 64'(master_req), 64'd0);
        end

`ifdef CB_MASTER_QUEUE_TIMEOUT_EN
        // Unacked read expires after TMO cycles of request.
        step(1'b1, 16'h0300, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < TMO - 1; i++) begin
            idle(1'b0);
            chk("tmo_wait", 64'(rsp_valid), 64'd0);
        end
        idle(1'b0);
        chk("tmo_valid", 64'(rsp_valid), 64'd1);
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
        chk("tmo_level", 64'(level), 64'd0);
        // Ack on the final allowed cycle is a normal completion.
        step(1'b1, 16'h0301, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < TMO - 1; i++) idle(1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_1234);
        chk("late_ack_valid", 64'(rsp_valid), 64'd1);
        chk("late_ack_err", 64'(rsp_err), 64'd0);
        chk("late_ack_rdata", 64'(rsp_rdata), 64'h1234);
`endif

        idle(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
